// File: rtl/mem_wb_pipe_pkg.sv
// Shared definitions for the MEM/WB stage: default widths and the packed
// pipeline entry type that neighbouring stages also use.
package mem_wb_pipe_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int IDX_W_DEF  = 4;

   typedef struct packed {
      logic                  reg_write;
      logic                  memto_reg;
      logic [DATA_W_DEF-1:0] data_out;
      logic [DATA_W_DEF-1:0] result;
      logic [IDX_W_DEF-1:0]  reg_write_index;
   } mem_wb_entry_t;

   // Payload width of an entry for non-default widths (same field order as mem_wb_entry_t)
   function automatic int entry_width(input int data_w, input int idx_w);
      return 2 * data_w + idx_w + 2;
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register. SKID=1 adds a second entry so that
// o_ready is registered; SKID=0 is a single register with combinational ready.
module pipe_skid_buf #(
   parameter int WIDTH = 8,
   parameter bit SKID  = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data
);

   logic             r_main_valid;
   logic [WIDTH-1:0] r_main_data;
   logic             w_acc_in;
   logic             w_acc_out;

   assign w_acc_in  = i_valid & o_ready;
   assign w_acc_out = r_main_valid & i_ready;
   assign o_valid   = r_main_valid;
   assign o_data    = r_main_data;

   if (SKID) begin : g_skid
      logic             r_skid_valid;
      logic [WIDTH-1:0] r_skid_data;

      assign o_ready = ~r_skid_valid;

      // NOTE: data registers are reset too so the outputs come out of reset at a known 0.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
         end else if (i_flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
         end else if (w_acc_out && r_skid_valid) begin
            // Skid is always the younger entry; o_ready=0 here so no input competes
            r_main_data  <= r_skid_data;
            r_skid_valid <= 1'b0;
         end else if (w_acc_in && (!r_main_valid || w_acc_out)) begin
            r_main_valid <= 1'b1;
            r_main_data  <= i_data;
         end else if (w_acc_in) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= i_data;
         end else if (w_acc_out) begin
            r_main_valid <= 1'b0;
         end
      end
   end else begin : g_single
      assign o_ready = ~r_main_valid | i_ready;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
         end else if (i_flush) begin
            r_main_valid <= 1'b0;
         end else if (w_acc_in) begin
            r_main_valid <= 1'b1;
            r_main_data  <= i_data;
         end else if (w_acc_out) begin
            r_main_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: skid-buffered entry register, write-back data select,
// bubble gating of the register write and a saturating retired-write counter.
module mem_wb_pipe
   import mem_wb_pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDX_W  = IDX_W_DEF,
   parameter bit SKID   = 1'b1,
   parameter int CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Flush,
   input  logic              Valid2,
   output logic              Ready2,
   input  logic              RegWrite2,
   input  logic              MemotoReg2,
   input  logic [DATA_W-1:0] DataOut2,
   input  logic [DATA_W-1:0] Result2,
   input  logic [IDX_W-1:0]  RegWriteIndex2,
   output logic              Valid3,
   input  logic              Ready3,
   output logic              RegWrite3,
   output logic              MemotoReg3,
   output logic [DATA_W-1:0] DataOut3,
   output logic [DATA_W-1:0] Result3,
   output logic [IDX_W-1:0]  RegWriteIndex3,
   output logic [DATA_W-1:0] WbData3,
   output logic [CNT_W-1:0]  RetireCount
);

   localparam int ENTRY_W = entry_width(DATA_W, IDX_W);

   logic [ENTRY_W-1:0] w_entry_in;
   logic [ENTRY_W-1:0] w_entry_out;
   logic               w_reg_write;
   logic               w_retire;
   logic [CNT_W-1:0]   r_retire_cnt;

   assign w_entry_in = {RegWrite2, MemotoReg2, DataOut2, Result2, RegWriteIndex2};

   pipe_skid_buf #(
      .WIDTH (ENTRY_W),
      .SKID  (SKID)
   ) u_buf (
      .i_clk   (Clk),
      .i_rst_n (Rst),
      .i_flush (Flush),
      .i_valid (Valid2),
      .o_ready (Ready2),
      .i_data  (w_entry_in),
      .o_valid (Valid3),
      .i_ready (Ready3),
      .o_data  (w_entry_out)
   );

   assign {w_reg_write, MemotoReg3, DataOut3, Result3, RegWriteIndex3} = w_entry_out;

   // Stale data left behind by a flush or drain is made inert here
   assign RegWrite3 = w_reg_write & Valid3;
   assign WbData3   = MemotoReg3 ? DataOut3 : Result3;
   assign w_retire  = Valid3 & Ready3 & RegWrite3;

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_retire_cnt <= '0;
      end else if (w_retire && (r_retire_cnt != {CNT_W{1'b1}})) begin
         r_retire_cnt <= r_retire_cnt + 1'b1;
      end
   end

   assign RetireCount = r_retire_cnt;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: a SKID=1 instance for the main stream tests
// and a SKID=0, CNT_W=4 instance for saturation and combinational ready.
module tb_mem_wb_pipe;

   localparam int DW = 16;
   localparam int IW = 4;

   logic Clk = 1'b0;
   logic Rst;
   always #5 Clk = ~Clk;

   // SKID=1 instance signals
   logic          a_flush, a_valid2, a_ready2, a_regwrite2, a_memto2;
   logic [DW-1:0] a_dout2, a_res2;
   logic [IW-1:0] a_idx2;
   logic          a_valid3, a_ready3, a_regwrite3, a_memto3;
   logic [DW-1:0] a_dout3, a_res3, a_wb3;
   logic [IW-1:0] a_idx3;
   logic [15:0]   a_cnt;

   // SKID=0, CNT_W=4 instance signals
   logic          b_flush, b_valid2, b_ready2, b_regwrite2, b_memto2;
   logic [DW-1:0] b_dout2, b_res2;
   logic [IW-1:0] b_idx2;
   logic          b_valid3, b_ready3, b_regwrite3, b_memto3;
   logic [DW-1:0] b_dout3, b_res3, b_wb3;
   logic [IW-1:0] b_idx3;
   logic [3:0]    b_cnt;

   mem_wb_pipe #(.DATA_W(DW), .IDX_W(IW), .SKID(1'b1), .CNT_W(16)) dut_a (
      .Clk(Clk), .Rst(Rst), .Flush(a_flush),
      .Valid2(a_valid2), .Ready2(a_ready2), .RegWrite2(a_regwrite2), .MemotoReg2(a_memto2),
      .DataOut2(a_dout2), .Result2(a_res2), .RegWriteIndex2(a_idx2),
      .Valid3(a_valid3), .Ready3(a_ready3), .RegWrite3(a_regwrite3), .MemotoReg3(a_memto3),
      .DataOut3(a_dout3), .Result3(a_res3), .RegWriteIndex3(a_idx3),
      .WbData3(a_wb3), .RetireCount(a_cnt)
   );

   mem_wb_pipe #(.DATA_W(DW), .IDX_W(IW), .SKID(1'b0), .CNT_W(4)) dut_b (
      .Clk(Clk), .Rst(Rst), .Flush(b_flush),
      .Valid2(b_valid2), .Ready2(b_ready2), .RegWrite2(b_regwrite2), .MemotoReg2(b_memto2),
      .DataOut2(b_dout2), .Result2(b_res2), .RegWriteIndex2(b_idx2),
      .Valid3(b_valid3), .Ready3(b_ready3), .RegWrite3(b_regwrite3), .MemotoReg3(b_memto3),
      .DataOut3(b_dout3), .Result3(b_res3), .RegWriteIndex3(b_idx3),
      .WbData3(b_wb3), .RetireCount(b_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   // Advance one rising edge and settle just after it
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic a_drive(input logic v, input logic rw, input logic m,
                          input logic [DW-1:0] d, input logic [DW-1:0] r);
      a_valid2 = v; a_regwrite2 = rw; a_memto2 = m; a_dout2 = d; a_res2 = r; a_idx2 = 4'd3;
   endtask

   task automatic b_drive(input logic v, input logic [DW-1:0] r);
      b_valid2 = v; b_regwrite2 = 1'b1; b_memto2 = 1'b0; b_dout2 = '0; b_res2 = r; b_idx2 = 4'd5;
   endtask

   initial begin
      Rst = 1'b0;
      a_flush = 1'b0; a_ready3 = 1'b0; a_drive(1'b0, 1'b0, 1'b0, '0, '0);
      b_flush = 1'b0; b_ready3 = 1'b0; b_drive(1'b0, '0);
      #12;
      check("rst_valid3",   a_valid3, 0);
      check("rst_ready2",   a_ready2, 1);
      check("rst_cnt",      a_cnt, 0);
      check("rst_wbdata",   a_wb3, 0);
      check("rst_b_ready2", b_ready2, 1);
      @(negedge Clk);
      Rst = 1'b1;

      // Pass-through with Ready3=1
      a_ready3 = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         a_drive(1'b1, 1'b1, 1'b0, 16'h0, 16'(i));
         tick();
         check("pt_valid3", a_valid3, 1);
         check("pt_wbdata", a_wb3, 32'(i));
         check("pt_regwr3", a_regwrite3, 1);
         check("pt_idx3",   a_idx3, 3);
      end
      a_drive(1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      check("pt_cnt",    a_cnt, 4);
      check("pt_empty",  a_valid3, 0);

      // Back-pressure fills main then skid
      a_ready3 = 1'b0;
      a_drive(1'b1, 1'b1, 1'b0, '0, 16'h1111);
      tick();
      check("bp_a_out",   a_wb3, 16'h1111);
      check("bp_ready_a", a_ready2, 1);
      a_drive(1'b1, 1'b1, 1'b0, '0, 16'h2222);
      tick();
      check("bp_hold_a",  a_wb3, 16'h1111);
      check("bp_ready_b", a_ready2, 0);
      a_drive(1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      check("bp_hold2",   a_wb3, 16'h1111);
      check("bp_valid",   a_valid3, 1);
      check("bp_cnt_hold", a_cnt, 4);
      a_ready3 = 1'b1;
      tick();
      check("bp_b_out",   a_wb3, 16'h2222);
      check("bp_b_valid", a_valid3, 1);
      check("bp_ready_up", a_ready2, 1);
      check("bp_cnt_a",   a_cnt, 5);
      tick();
      check("bp_drained", a_valid3, 0);
      check("bp_cnt_b",   a_cnt, 6);

      // Memory select and non-writing entry
      a_drive(1'b1, 1'b1, 1'b1, 16'hBEEF, 16'h1234);
      tick();
      check("ms_wbdata", a_wb3, 16'hBEEF);
      check("ms_regwr3", a_regwrite3, 1);
      a_drive(1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h5555);
      tick();
      check("nw_wbdata", a_wb3, 16'h5555);
      check("nw_regwr3", a_regwrite3, 0);
      check("nw_cnt",    a_cnt, 7);
      a_drive(1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      check("nw_cnt2",   a_cnt, 7);
      check("nw_empty",  a_valid3, 0);

      // Flush with main and skid both full
      a_ready3 = 1'b0;
      a_drive(1'b1, 1'b1, 1'b0, '0, 16'h3333);
      tick();
      a_drive(1'b1, 1'b1, 1'b0, '0, 16'h4444);
      tick();
      check("fl_full", a_ready2, 0);
      a_flush = 1'b1;
      a_drive(1'b1, 1'b1, 1'b0, '0, 16'h6666);
      tick();
      check("fl_valid3", a_valid3, 0);
      check("fl_regwr3", a_regwrite3, 0);
      check("fl_ready2", a_ready2, 1);
      a_flush = 1'b0;
      a_drive(1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      check("fl_no_ghost", a_valid3, 0);
      check("fl_cnt",      a_cnt, 7);

      // Flush overrides an accepted input; same-cycle retirement still counts
      a_drive(1'b1, 1'b1, 1'b0, '0, 16'h8888);
      tick();
      check("fl2_held", a_wb3, 16'h8888);
      a_ready3 = 1'b1;
      a_flush  = 1'b1;
      a_drive(1'b1, 1'b1, 1'b0, '0, 16'h9999);
      tick();
      check("fl2_valid3", a_valid3, 0);
      check("fl2_cnt",    a_cnt, 8);
      a_flush = 1'b0;
      a_drive(1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      check("fl2_dropped", a_valid3, 0);

      // Saturation on the CNT_W=4 instance
      b_ready3 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         b_drive(1'b1, 16'(i + 16'h100));
         tick();
      end
      b_drive(1'b0, '0);
      tick();
      check("sat_cnt",   b_cnt, 15);
      check("sat_empty", b_valid3, 0);

      // SKID=0 back-pressure: Ready2 follows Ready3 combinationally
      b_ready3 = 1'b0;
      b_drive(1'b1, 16'h1111);
      tick();
      check("s0_a_out",   b_wb3, 16'h1111);
      check("s0_ready_lo", b_ready2, 0);
      b_drive(1'b1, 16'h2222);
      tick();
      check("s0_a_hold",  b_wb3, 16'h1111);
      b_ready3 = 1'b1;
      #1;
      check("s0_ready_comb", b_ready2, 1);
      tick();
      check("s0_b_out",   b_wb3, 16'h2222);
      b_ready3 = 1'b0;
      b_drive(1'b0, '0);
      #1;
      check("s0_ready_drop", b_ready2, 0);
      tick();
      check("s0_b_hold",  b_wb3, 16'h2222);
      b_ready3 = 1'b1;
      tick();
      check("s0_drained", b_valid3, 0);
      check("s0_cnt_sat", b_cnt, 15);

      // Reset mid-stream with two entries held
      a_ready3 = 1'b0;
      a_drive(1'b1, 1'b1, 1'b0, '0, 16'hAAAA);
      tick();
      a_drive(1'b1, 1'b1, 1'b0, '0, 16'hBBBB);
      tick();
      a_drive(1'b0, 1'b0, 1'b0, '0, '0);
      check("mr_pre_valid", a_valid3, 1);
      #2;
      Rst = 1'b0;
      #1;
      check("mr_valid3", a_valid3, 0);
      check("mr_regwr3", a_regwrite3, 0);
      check("mr_cnt",    a_cnt, 0);
      check("mr_b_cnt",  b_cnt, 0);
      @(negedge Clk);
      Rst = 1'b1;
      tick();
      check("mr_ready2", a_ready2, 1);
      check("mr_empty",  a_valid3, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
